// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//   Shared types for the generic pipeline stage register (pipe_stage_reg).
//   - stage_state_e    : occupancy state of a stage (empty / one entry / two).
//   - wb_src_e, mem_op_e : control-type enums reused by the per-stage bundles.
//   - *_ctrl_t         : packed control bundles for each stage boundary,
//                        all 8 bits wide so they fit the default CTRL_W.
//   - *_CTRL_NOP       : bubble encodings for each bundle; feed these to the
//                        CTRL_NOP parameter of the matching stage instance.
//   - STAT_*_W         : widths of the optional saturating statistics counters.
// -----------------------------------------------------------------------------
package pipe_pkg;

    // Stage occupancy. ST_SKID is only reachable in the two-entry build.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stage_state_e;

    // Write-back source select.
    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_src_e;

    // Memory operation.
    typedef enum logic [2:0] {
        MEM_NONE = 3'd0,
        MEM_LB   = 3'd1,
        MEM_LH   = 3'd2,
        MEM_LW   = 3'd3,
        MEM_LBU  = 3'd4,
        MEM_LHU  = 3'd5,
        MEM_SB   = 3'd6,
        MEM_SW   = 3'd7
    } mem_op_e;

    // IF/ID: fetch-side hints only.
    typedef struct packed {
        logic       pred_taken;
        logic       fetch_fault;
        logic [5:0] rsvd;
    } if_id_ctrl_t;

    // ID/EX: full decoded control.
    typedef struct packed {
        logic    reg_write;
        wb_src_e wb_src;
        mem_op_e mem_op;
        logic    branch;
        logic    jump;
    } id_ex_ctrl_t;

    // EX/MEM: branch resolution is done, memory and write-back remain.
    typedef struct packed {
        logic       reg_write;
        wb_src_e    wb_src;
        mem_op_e    mem_op;
        logic [1:0] rsvd;
    } ex_mem_ctrl_t;

    // MEM/WB: write-back only.
    typedef struct packed {
        logic       reg_write;
        wb_src_e    wb_src;
        logic [4:0] rsvd;
    } mem_wb_ctrl_t;

    // A bubble must never write the register file or touch memory.
    localparam if_id_ctrl_t IF_ID_CTRL_NOP = '{
        pred_taken: 1'b0, fetch_fault: 1'b0, rsvd: 6'd0};
    localparam id_ex_ctrl_t ID_EX_CTRL_NOP = '{
        reg_write: 1'b0, wb_src: WB_ALU, mem_op: MEM_NONE, branch: 1'b0, jump: 1'b0};
    localparam ex_mem_ctrl_t EX_MEM_CTRL_NOP = '{
        reg_write: 1'b0, wb_src: WB_ALU, mem_op: MEM_NONE, rsvd: 2'd0};
    localparam mem_wb_ctrl_t MEM_WB_CTRL_NOP = '{
        reg_write: 1'b0, wb_src: WB_ALU, rsvd: 5'd0};

    localparam int STAGE_CTRL_W = $bits(id_ex_ctrl_t);

    // Statistics counter widths.
    localparam int STAT_CNT_W   = 32;
    localparam int STAT_FLUSH_W = 16;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Event counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk    in   clock
//     rst    in   synchronous active-high reset, clears the count
//     inc_i  in   count one event on this edge
//     cnt_o  out  current count (WIDTH bits)
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        if (&v) begin
            return v;
        end
        return v + WIDTH'(1);
    endfunction

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Generic pipeline stage register carrying a control bundle and a data
//   payload under a valid/ready handshake. Replaces the fixed IF/ID, ID/EX,
//   EX/MEM and MEM/WB registers.
//
//   SKID=1: two entries (main + skid). in_ready is a flop, so backpressure
//           never forms a combinational ready chain through the pipeline.
//   SKID=0: one entry, in_ready = !out_valid | out_ready (combinational).
//
//   Whenever out_valid=0 the outputs present CTRL_NOP / 0, so downstream
//   decode can use out_ctrl without gating on valid.
//
//   Ports:
//     clk, rst           clock, synchronous active-high reset
//     flush              discard all held entries (and any entry offered now)
//     in_valid/in_ready  upstream handshake
//     in_ctrl, in_data   upstream control bundle / payload
//     out_valid/out_ready downstream handshake
//     out_ctrl, out_data head control bundle / payload
//
//   Optional: define PIPE_STAGE_REG_STATS_EN to add saturating counters
//     stat_stall_cnt  (32) cycles with out_valid & !out_ready
//     stat_bubble_cnt (32) cycles with out_valid = 0
//     stat_flush_cnt  (16) flush pulses
//   These clear on rst only; flush leaves them alone.
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                CTRL_W   = 8,
    parameter int                DATA_W   = 101,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
    parameter int                SKID     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_REG_STATS_EN
    ,
    output logic [STAT_CNT_W-1:0]   stat_stall_cnt,
    output logic [STAT_CNT_W-1:0]   stat_bubble_cnt,
    output logic [STAT_FLUSH_W-1:0] stat_flush_cnt
`endif
);

    stage_state_e      state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    logic              head_vld;
    logic              in_fire;
    logic              out_fire;

    assign head_vld = (state_q != ST_EMPTY);

    // In the skid build ready comes straight from a flop; the single-entry
    // build may accept in the same cycle the head leaves.
    assign in_ready = (SKID != 0) ? in_ready_q : (!head_vld || out_ready);

    assign in_fire  = in_valid & in_ready;
    assign out_fire = head_vld & out_ready;

    // Next-state and entry steering. rst and flush both empty the stage;
    // any entry offered in that cycle is simply never captured.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        if (rst || flush) begin
            state_d = ST_EMPTY;
        end else if (SKID != 0) begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d     = ST_FULL;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_fire) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (in_fire) begin
                        // Head is stalled: park the newcomer behind it.
                        state_d     = ST_SKID;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_fire) begin
                        state_d     = ST_FULL;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end else begin
            if (in_fire) begin
                state_d     = ST_FULL;
                main_ctrl_d = in_ctrl;
                main_data_d = in_data;
            end else if (out_fire) begin
                state_d = ST_EMPTY;
            end
        end

        // Registered ready: accept next cycle unless both slots will be used.
        in_ready_d = (state_d != ST_SKID);
    end

    // Stage register: control state (reset) and payload slots (no reset;
    // a slot's contents are only visible while the state marks it valid).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        main_ctrl_q <= main_ctrl_d;
        main_data_q <= main_data_d;
        skid_ctrl_q <= skid_ctrl_d;
        skid_data_q <= skid_data_d;
    end

    // Bubbles always present the NOP encoding and a zero payload.
    assign out_valid = head_vld;
    assign out_ctrl  = head_vld ? main_ctrl_q : CTRL_NOP;
    assign out_data  = head_vld ? main_data_q : '0;

`ifdef PIPE_STAGE_REG_STATS_EN
    sat_counter #(.WIDTH(STAT_CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (head_vld & ~out_ready),
        .cnt_o (stat_stall_cnt)
    );

    sat_counter #(.WIDTH(STAT_CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (~head_vld),
        .cnt_o (stat_bubble_cnt)
    );

    sat_counter #(.WIDTH(STAT_FLUSH_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (flush),
        .cnt_o (stat_flush_cnt)
    );
`endif

endmodule
